// File: rtl/mem_path_mux_pkg.sv
// rtl/mem_path_mux_pkg.sv - shared constants and select encodings for the memory path
//
// Contents:
//   DATA_W, IMM_W          default address/data and move-immediate widths
//   SEL_ADD_PASS/HOLD      address bus select encodings
//   SEL_LDR_ALU/RAM        load multiplexer select encodings
package mem_path_mux_pkg;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;

    localparam logic SEL_ADD_PASS = 1'b0;
    localparam logic SEL_ADD_HOLD = 1'b1;

    localparam logic SEL_LDR_ALU = 1'b0;
    localparam logic SEL_LDR_RAM = 1'b1;

endpackage

// File: rtl/mem_path_mux_ldr_mux.sv
// rtl/mem_path_mux_ldr_mux.sv - 2:1 load mux with a zero-extending A leg
//
// Ports:
//   a    in  A_W  non-memory source, zero-extended to W
//   b    in  W    RAM read data
//   sel  in  1    SEL_LDR_ALU selects a, SEL_LDR_RAM selects b
//   y    out W    selected data
module mem_path_mux_ldr_mux
    import mem_path_mux_pkg::*;
#(
    parameter int W   = DATA_W,
    parameter int A_W = DATA_W
) (
    input  logic [A_W-1:0] a,
    input  logic [W-1:0]   b,
    input  logic           sel,
    output logic [W-1:0]   y
);

    logic [W-1:0] a_ext;

    // Size cast of an unsigned vector fills the upper bits with zeros.
    assign a_ext = W'(a);

    // Only the selected leg reaches y, so an X on the other leg stays hidden.
    always_comb begin
        y = '0;
        case (sel)
            SEL_LDR_ALU: y = a_ext;
            SEL_LDR_RAM: y = b;
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/mem_path_mux.sv
// rtl/mem_path_mux.sv - memory-stage address bus with hold register and writeback load muxes
//
// Ports:
//   clk         in  1       rising-edge clock for the address hold register
//   Reset       in  1       async active-high; clears addr_q and forces out_add to 0
//   SR1         in  DATA_W  source-register value used as the address
//   sel_add     in  1       0 = pass SR1 and capture it, 1 = drive held address
//   ALU_result  in  DATA_W  ALU output
//   RAM_out     in  DATA_W  RAM read data
//   IV_Mov      in  IMM_W   move immediate
//   sel_LDR     in  1       0 = non-memory source, 1 = RAM_out
//   out_add     out DATA_W  RAM address
//   out_LDR     out DATA_W  writeback data for ALU and LDR instructions
//   out_ADR     out DATA_W  data for ADR and STR paths
module mem_path_mux
    import mem_path_mux_pkg::*;
#(
    parameter int DATA_W = mem_path_mux_pkg::DATA_W,
    parameter int IMM_W  = mem_path_mux_pkg::IMM_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] SR1,
    input  logic              sel_add,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] RAM_out,
    input  logic [IMM_W-1:0]  IV_Mov,
    input  logic              sel_LDR,
    output logic [DATA_W-1:0] out_add,
    output logic [DATA_W-1:0] out_LDR,
    output logic [DATA_W-1:0] out_ADR
);

    logic [DATA_W-1:0] addr_q;

    // Capture follows the pass-through: whatever is driven while passing
    // becomes the address held once sel_add switches to hold.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            addr_q <= '0;
        end else if (sel_add == SEL_ADD_PASS) begin
            addr_q <= SR1;
        end
    end

    // Reset overrides the pass path too, so out_add is 0 as soon as Reset rises.
    always_comb begin
        out_add = '0;
        if (!Reset) begin
            case (sel_add)
                SEL_ADD_PASS: out_add = SR1;
                SEL_ADD_HOLD: out_add = addr_q;
                default:      out_add = '0;
            endcase
        end
    end

    mem_path_mux_ldr_mux #(
        .W   (DATA_W),
        .A_W (DATA_W)
    ) u_ldr_alu_ram (
        .a   (ALU_result),
        .b   (RAM_out),
        .sel (sel_LDR),
        .y   (out_LDR)
    );

    mem_path_mux_ldr_mux #(
        .W   (DATA_W),
        .A_W (IMM_W)
    ) u_ldr_imm_ram (
        .a   (IV_Mov),
        .b   (RAM_out),
        .sel (sel_LDR),
        .y   (out_ADR)
    );

endmodule

// File: tb/tb_mem_path_mux.sv
// tb/tb_mem_path_mux.sv - self-checking bench for mem_path_mux
module tb_mem_path_mux;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] SR1;
    logic        sel_add;
    logic [31:0] ALU_result;
    logic [31:0] RAM_out;
    logic [15:0] IV_Mov;
    logic        sel_LDR;
    logic [31:0] out_add;
    logic [31:0] out_LDR;
    logic [31:0] out_ADR;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] model_addr;

    mem_path_mux #(
        .DATA_W (32),
        .IMM_W  (16)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .SR1        (SR1),
        .sel_add    (sel_add),
        .ALU_result (ALU_result),
        .RAM_out    (RAM_out),
        .IV_Mov     (IV_Mov),
        .sel_LDR    (sel_LDR),
        .out_add    (out_add),
        .out_LDR    (out_LDR),
        .out_ADR    (out_ADR)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        Reset = 1'b1; SR1 = 32'hDEADBEEF; sel_add = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (out_add !== exp) begin
            errors++; $display("FAIL reset_assert out_add got %h want %h", out_add, exp);
        end
        @(negedge clk);
        Reset = 1'b0; sel_add = 1'b1;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (out_add !== exp) begin
            errors++; $display("FAIL reset_release_hold out_add got %h want %h", out_add, exp);
        end
        @(posedge clk); #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (out_add !== exp) begin
            errors++; $display("FAIL reset_hold_after_clk out_add got %h want %h", out_add, exp);
        end
    endtask

    task automatic test_addr_pass_hold();
        @(negedge clk);
        sel_add = 1'b0; SR1 = 32'h00000040;
        exp_q.push_back(32'h40);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (out_add !== exp) begin
            errors++; $display("FAIL addr_pass out_add got %h want %h", out_add, exp);
        end
        @(posedge clk);
        @(negedge clk);
        sel_add = 1'b1; SR1 = 32'h00000080;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h40);
            @(posedge clk); #1;
            exp = exp_q.pop_front(); checks++;
            if (out_add !== exp) begin
                errors++; $display("FAIL addr_hold[%0d] out_add got %h want %h", i, out_add, exp);
            end
        end
    endtask

    task automatic test_ldr_mux();
        ALU_result = 32'h12345678; RAM_out = 32'hCAFEF00D; sel_LDR = 1'b0;
        exp_q.push_back(32'h12345678);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (out_LDR !== exp) begin
            errors++; $display("FAIL ldr_alu out_LDR got %h want %h", out_LDR, exp);
        end
        sel_LDR = 1'b1;
        exp_q.push_back(32'hCAFEF00D);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (out_LDR !== exp) begin
            errors++; $display("FAIL ldr_ram out_LDR got %h want %h", out_LDR, exp);
        end
    endtask

    task automatic test_adr_mux();
        IV_Mov = 16'hFFFF; sel_LDR = 1'b0;
        exp_q.push_back(32'h0000FFFF);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (out_ADR !== exp) begin
            errors++; $display("FAIL adr_zext out_ADR got %h want %h", out_ADR, exp);
        end
        RAM_out = 32'hA5A5A5A5; sel_LDR = 1'b1;
        exp_q.push_back(32'hA5A5A5A5);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (out_ADR !== exp) begin
            errors++; $display("FAIL adr_ram out_ADR got %h want %h", out_ADR, exp);
        end
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        sel_add = 1'b0; SR1 = 32'h40;
        @(posedge clk);
        @(negedge clk);
        sel_add = 1'b1; SR1 = 32'h99;
        #1;
        exp_q.push_back(32'h40);
        exp = exp_q.pop_front(); checks++;
        if (out_add !== exp) begin
            errors++; $display("FAIL midhold_before out_add got %h want %h", out_add, exp);
        end
        Reset = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (out_add !== exp) begin
            errors++; $display("FAIL midhold_reset out_add got %h want %h", out_add, exp);
        end
        Reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'h0);
            @(posedge clk); #1;
            exp = exp_q.pop_front(); checks++;
            if (out_add !== exp) begin
                errors++; $display("FAIL midhold_after[%0d] out_add got %h want %h", i, out_add, exp);
            end
        end
        @(negedge clk);
        sel_add = 1'b0; SR1 = 32'h40;
        @(posedge clk);
        @(negedge clk);
        sel_add = 1'b1;
        exp_q.push_back(32'h40);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (out_add !== exp) begin
            errors++; $display("FAIL midhold_recapture out_add got %h want %h", out_add, exp);
        end
    endtask

    task automatic test_x_isolation();
        RAM_out = 'x; sel_LDR = 1'b0; ALU_result = 32'd5; IV_Mov = 16'd7;
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd7);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (out_LDR !== exp) begin
            errors++; $display("FAIL xiso_ldr out_LDR got %h want %h", out_LDR, exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (out_ADR !== exp) begin
            errors++; $display("FAIL xiso_adr out_ADR got %h want %h", out_ADR, exp);
        end
    endtask

    // Random traffic against a bench-side model of the hold register.
    task automatic test_back_to_back();
        logic [31:0] want_ldr;
        logic [31:0] want_adr;
        logic [31:0] want_add;
        @(negedge clk);
        sel_add = 1'b0; SR1 = 32'h0;
        @(posedge clk);
        model_addr = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            sel_add    = 1'($urandom_range(0, 1));
            SR1        = $urandom;
            ALU_result = $urandom;
            RAM_out    = $urandom;
            IV_Mov     = 16'($urandom);
            sel_LDR    = 1'($urandom_range(0, 1));
            want_add = sel_add ? model_addr : SR1;
            want_ldr = sel_LDR ? RAM_out : ALU_result;
            want_adr = sel_LDR ? RAM_out : {16'h0, IV_Mov};
            exp_q.push_back(want_add);
            exp_q.push_back(want_ldr);
            exp_q.push_back(want_adr);
            #1;
            exp = exp_q.pop_front(); checks++;
            if (out_add !== exp) begin
                errors++; $display("FAIL b2b_add[%0d] out_add got %h want %h", i, out_add, exp);
            end
            exp = exp_q.pop_front(); checks++;
            if (out_LDR !== exp) begin
                errors++; $display("FAIL b2b_ldr[%0d] out_LDR got %h want %h", i, out_LDR, exp);
            end
            exp = exp_q.pop_front(); checks++;
            if (out_ADR !== exp) begin
                errors++; $display("FAIL b2b_adr[%0d] out_ADR got %h want %h", i, out_ADR, exp);
            end
            @(posedge clk);
            if (!sel_add) model_addr = SR1;
        end
    endtask

    initial begin
        Reset = 1'b1; SR1 = '0; sel_add = 1'b0;
        ALU_result = '0; RAM_out = '0; IV_Mov = '0; sel_LDR = 1'b0;
        test_reset();
        test_addr_pass_hold();
        test_ldr_mux();
        test_adr_mux();
        test_reset_mid_hold();
        test_x_isolation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_path_mux.md
# mem_path_mux

Memory-path steering block for the CPU's memory stage. It produces the RAM address through an address-bus stage with a hold register, and selects register-writeback data through two 2:1 load multiplexers. One multiplexer chooses between the ALU result and RAM read data. The other chooses between a zero-extended move immediate and RAM read data. It sits between the decode/ALU outputs and the RAM/register-file ports, and is driven by the memory controller's `sel_add`/`sel_LDR` decode.

## Interface
Parameters:
- `DATA_W`, default 32: width of the address and data paths.
- `IMM_W`, default 16: width of the move immediate; must be ≤ `DATA_W`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock for the address hold register.
- `Reset`  in  1  asynchronous, active-high; clears the hold register and forces `out_add` to 0.
- `SR1`  in  DATA_W  source-register value used as the address.
- `sel_add`  in  1  0 = pass `SR1` and capture it; 1 = drive the held address.
- `ALU_result`  in  DATA_W  ALU output.
- `RAM_out`  in  DATA_W  RAM read data.
- `IV_Mov`  in  IMM_W  move immediate.
- `sel_LDR`  in  1  0 = non-memory source; 1 = `RAM_out`.
- `out_add`  out  DATA_W  RAM address.
- `out_LDR`  out  DATA_W  writeback data for ALU and LDR instructions.
- `out_ADR`  out  DATA_W  data for ADR and STR paths.

## Operation
Address bus:
- While `Reset` = 1: `out_add` = 0.
- Otherwise, `sel_add` = 0: `out_add` = `SR1`, combinational pass-through.
- Otherwise, `sel_add` = 1: `out_add` = `addr_q`.

Address hold register `addr_q`:
- Async clear to 0 on `Reset`.
- On each rising `clk` with `Reset` = 0 and `sel_add` = 0: `addr_q` <= `SR1`.
- With `sel_add` = 1: `addr_q` holds its value.

Load multiplexers:
- `out_LDR` = `sel_LDR` ? `RAM_out` : `ALU_result`.
- `out_ADR` = `sel_LDR` ? `RAM_out` : zero-extend(`IV_Mov`) to `DATA_W`. Upper `DATA_W`-`IMM_W` bits are 0; no sign extension.
- Both muxes are purely combinational and unaffected by `Reset`.

No X propagation from unselected inputs: an X on the unselected leg must not appear on the output.

## Timing
- `out_LDR`, `out_ADR`, and `out_add` in pass mode: zero-cycle combinational paths.
- `out_add` in hold mode: reflects `SR1` as it was at the last rising edge with `sel_add` = 0.
- Reset values: `addr_q` = 0 and `out_add` = 0 immediately on `Reset` assertion. `out_LDR`/`out_ADR` follow their inputs regardless of `Reset`.
- Reset mid-hold: the held address is lost; after deassertion with `sel_add` = 1, `out_add` = 0 until a capture edge occurs.
- `Reset` deasserting coincident with a `clk` edge: no capture on that edge; capture begins on the next edge.
- `sel_add` changing at a clock edge: the value of `sel_add` sampled at the edge decides capture.

## Structure
- Shared CPU package holds the `DATA_W`/`IMM_W` constants and the select encodings: `SEL_ADD_PASS`=0, `SEL_ADD_HOLD`=1, `SEL_LDR_ALU`=0, `SEL_LDR_RAM`=1.
- One natural sub-module: `ldr_mux`, a parameterised 2:1 mux with a zero-extending A leg (width `A_W`).
  - Instantiated twice: ALU/RAM and immediate/RAM.
- The address bus and its hold register live in the top level.

## Test plan
1. Reset: assert `Reset` with `SR1`=0xDEADBEEF, `sel_add`=0 -> `out_add`=0. Deassert, `sel_add`=1 -> `out_add`=0.
2. Address pass and hold:
   - `sel_add`=0, `SR1`=0x00000040, clock -> `out_add`=0x40.
   - Set `sel_add`=1, `SR1`=0x80 -> `out_add` stays 0x40 over 3 clocks.
3. LDR mux: `ALU_result`=0x12345678, `RAM_out`=0xCAFEF00D.
   - `sel_LDR`=0 -> `out_LDR`=0x12345678.
   - `sel_LDR`=1 -> 0xCAFEF00D, with no clock required.
4. ADR mux: `IV_Mov`=0xFFFF.
   - `sel_LDR`=0 -> `out_ADR`=0x0000FFFF (zero-extended).
   - `sel_LDR`=1 with `RAM_out`=0xA5A5A5A5 -> 0xA5A5A5A5.
5. Reset mid-hold: hold 0x40 with `sel_add`=1, pulse `Reset` between edges -> `out_add`=0 immediately and remains 0 until `sel_add`=0 plus a clock.
6. X isolation: `RAM_out`=X, `sel_LDR`=0, `ALU_result`=5, `IV_Mov`=7 -> `out_LDR`=5 and `out_ADR`=7, with no X on either.
